// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller: size/error codes,
// FSM states, the registered load context and the access-error priority rule.
package mem_access_ctrl_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_SIZE     = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_CAP = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0] size;
    logic [1:0] offset;
    logic       is_unsigned;
  } ld_ctx_t;

  // Error priority: reserved size > out of range > misaligned.
  function automatic logic [1:0] access_err(input logic [1:0] size,
                                            input logic [1:0] offset,
                                            input logic       out_of_range);
    if (size == SIZE_RSVD) return ERR_SIZE;
    if (out_of_range) return ERR_RANGE;
    if ((size == SIZE_HALF) && offset[0]) return ERR_MISALIGN;
    if ((size == SIZE_WORD) && (offset != 2'b00)) return ERR_MISALIGN;
    return ERR_OK;
  endfunction

endpackage

// File: rtl/mem_load_extract.sv
// Selects the addressed lane of a memory word, moves it to bit 0 and
// sign- or zero-extends it to 32 bits.
module mem_load_extract
  import mem_access_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word >> {offset, 3'b000};
    data    = shifted;
    case (size)
      SIZE_BYTE: data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
      default:   data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store front end for a word-addressed data memory: byte-lane strobes,
// store replication, load extraction and alignment/range checking.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned MEM_ADDR_BITS = 20,
  parameter int unsigned MEM_DATA_BITS = 32
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_wdata,
  output logic                     resp_valid,
  output logic [31:0]              resp_rdata,
  output logic [1:0]               resp_err,
  output logic [MEM_ADDR_BITS-1:0] mem_addr,
  output logic [31:0]              mem_data_in,
  output logic [3:0]               mem_sel,
  output logic                     mem_str,
  output logic                     mem_ld,
  input  logic [31:0]              mem_data_out
);

  localparam int unsigned RANGE_LSB = MEM_ADDR_BITS + 2;

  if (MEM_DATA_BITS != 32) begin : g_width_check
    $error("mem_access_ctrl supports only MEM_DATA_BITS = 32");
  end

  state_t      state, state_nxt;
  ld_ctx_t     ctx_q, ctx_d;
  logic        accept;
  logic        out_of_range;
  logic [1:0]  acc_err;
  logic [31:0] ld_result;

  assign out_of_range = |(req_addr >> RANGE_LSB);
  assign acc_err      = access_err(req_size, req_addr[1:0], out_of_range);
  assign req_ready    = (state == IDLE) && !clr;
  assign ctx_d        = '{size: req_size, offset: req_addr[1:0], is_unsigned: req_unsigned};

  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state plus memory-side strobes, driven only in the accept cycle.
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    mem_addr    = '0;
    mem_data_in = '0;
    mem_sel     = '0;
    mem_str     = 1'b0;
    mem_ld      = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && !clr) begin
          accept = 1'b1;
          if (acc_err == ERR_OK) begin
            mem_addr = req_addr[MEM_ADDR_BITS+1:2];
            case (req_size)
              SIZE_BYTE: begin
                mem_sel     = 4'b0001 << req_addr[1:0];
                mem_data_in = {4{req_wdata[7:0]}};
              end
              SIZE_HALF: begin
                mem_sel     = 4'b0011 << req_addr[1:0];
                mem_data_in = {2{req_wdata[15:0]}};
              end
              default: begin
                mem_sel     = 4'b1111;
                mem_data_in = req_wdata;
              end
            endcase
            if (req_we) begin
              mem_str = 1'b1;
            end else begin
              mem_ld    = 1'b1;
              state_nxt = RD_CAP;
            end
          end
        end
      end
      RD_CAP:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  mem_load_extract u_extract (
    .word        (mem_data_out),
    .offset      (ctx_q.offset),
    .size        (ctx_q.size),
    .is_unsigned (ctx_q.is_unsigned),
    .data        (ld_result)
  );

  // resp_rdata doubles as the load result register; it is loaded in RD_CAP
  // so the pulse lands in RESP.
  always_ff @(posedge clk) begin
    if (clr) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= ERR_OK;
      ctx_q      <= '0;
    end else begin
      resp_valid <= 1'b0;
      if (accept) ctx_q <= ctx_d;
      if (accept && (req_we || (acc_err != ERR_OK))) begin
        resp_valid <= 1'b1;
        resp_rdata <= '0;
        resp_err   <= acc_err;
      end else if (state == RD_CAP) begin
        resp_valid <= 1'b1;
        resp_rdata <= ld_result;
        resp_err   <= ERR_OK;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed vector table, reset/back-to-back
// sequences and randomized accesses against a byte-array reference model.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic [19:0] mem_addr;
  logic [31:0] mem_data_in;
  logic [3:0]  mem_sel;
  logic        mem_str, mem_ld;
  logic [31:0] mem_data_out;

  int checks = 0;
  int errors = 0;

  mem_access_ctrl #(.MEM_ADDR_BITS(20), .MEM_DATA_BITS(32)) dut (
    .clk(clk), .clr(clr),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_sel(mem_sel),
    .mem_str(mem_str), .mem_ld(mem_ld), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // Environment memory: registered, sel-masked read data, zero when idle.
  logic [31:0] mem_words [0:1023];
  logic [31:0] env_rd;
  always @(posedge clk) begin
    env_rd = '0;
    for (int i = 0; i < 4; i++) begin
      if (mem_sel[i]) env_rd[8*i +: 8] = mem_words[mem_addr[9:0]][8*i +: 8];
      if (mem_str && mem_sel[i]) mem_words[mem_addr[9:0]][8*i +: 8] <= mem_data_in[8*i +: 8];
    end
    mem_data_out <= mem_ld ? env_rd : 32'h0;
  end

  // Reference model: byte-addressed memory image of the low 4 KB.
  logic [7:0] ref_mem [0:4095];

  function automatic logic [1:0] m_err(input logic [1:0] sz, input logic [31:0] a);
    int unsigned nbytes;
    if (sz == 2'd3) return 2'b11;
    if (a >= 32'h0040_0000) return 2'b10;
    nbytes = 32'd1 << sz;
    if ((a % nbytes) != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
    longint v = 0;
    int n = 1 << sz;
    for (int i = n - 1; i >= 0; i--) v = v * 256 + longint'(ref_mem[int'(a[11:0]) + i]);
    if (!uns && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  function automatic logic [3:0] m_sel(input logic [1:0] sz, input logic [31:0] a);
    int n = 1 << sz;
    logic [3:0] s = '0;
    for (int i = 0; i < n && i < 4; i++) s[int'(a[1:0]) + i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] m_din(input logic [1:0] sz, input logic [31:0] wd);
    int n = (sz == 2'd3) ? 4 : (1 << sz);
    logic [31:0] d;
    for (int i = 0; i < 4; i++) d[8*i +: 8] = wd[8*(i % n) +: 8];
    return d;
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    for (int i = 0; i < (1 << sz); i++) ref_mem[int'(a[11:0]) + i] = wd[8*i +: 8];
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One isolated transaction: cycle-0 memory strobes, then the response.
  task automatic do_req(input string nm, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [1:0] e_err,
                        input logic [31:0] e_rdata, input logic [3:0] e_sel, input logic [31:0] e_din);
    logic ok;
    ok = (e_err == 2'b00);
    @(negedge clk);
    check({nm, "_idle_rv"}, 32'(resp_valid), 32'd0);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    #1;
    check({nm, "_ready"}, 32'(req_ready), 32'd1);
    check({nm, "_str"}, 32'(mem_str), 32'(ok && we));
    check({nm, "_ld"}, 32'(mem_ld), 32'(ok && !we));
    check({nm, "_sel"}, 32'(mem_sel), ok ? 32'(e_sel) : 32'd0);
    check({nm, "_maddr"}, 32'(mem_addr), ok ? 32'(addr[21:2]) : 32'd0);
    if (ok && we) check({nm, "_din"}, mem_data_in, e_din);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    if (!ok || we) begin
      check({nm, "_rv"}, 32'(resp_valid), 32'd1);
      check({nm, "_err"}, 32'(resp_err), 32'(e_err));
      check({nm, "_rdata"}, resp_rdata, 32'd0);
    end else begin
      check({nm, "_cap_rv"}, 32'(resp_valid), 32'd0);
      check({nm, "_cap_ld"}, 32'(mem_ld), 32'd0);
      check({nm, "_cap_ready"}, 32'(req_ready), 32'd0);
      @(negedge clk);
      check({nm, "_rv"}, 32'(resp_valid), 32'd1);
      check({nm, "_err"}, 32'(resp_err), 32'd0);
      check({nm, "_rdata"}, resp_rdata, e_rdata);
    end
    if (ok && we) ref_store(sz, addr, wd);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [1:0]  err;
    logic [31:0] rdata;
    logic [3:0]  sel;
    logic [31:0] din;
  } vec_t;

  vec_t vecs [19];
  int   pulses;

  initial begin
    for (int i = 0; i < 1024; i++) mem_words[i] = '0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = '0;

    vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 2'b00, 32'h0,         4'hF, 32'hDEAD_BEEF};
    vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0,         2'b00, 32'hDEAD_BEEF, 4'hF, 32'h0};
    vecs[2]  = '{1'b1, 2'd0, 1'b0, 32'h0000_0103, 32'h0000_0080, 2'b00, 32'h0,         4'h8, 32'h8080_8080};
    vecs[3]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0,         2'b00, 32'hFFFF_FF80, 4'h8, 32'h0};
    vecs[4]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0,         2'b00, 32'h0000_0080, 4'h8, 32'h0};
    vecs[5]  = '{1'b1, 2'd1, 1'b0, 32'h0000_0102, 32'h0000_8001, 2'b00, 32'h0,         4'hC, 32'h8001_8001};
    vecs[6]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0102, 32'h0,         2'b00, 32'hFFFF_8001, 4'hC, 32'h0};
    vecs[7]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0102, 32'h0,         2'b00, 32'h0000_8001, 4'hC, 32'h0};
    vecs[8]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0101, 32'h0,         2'b01, 32'h0,         4'h0, 32'h0};
    vecs[9]  = '{1'b0, 2'd1, 1'b0, 32'h0040_0000, 32'h0,         2'b10, 32'h0,         4'h0, 32'h0};
    vecs[10] = '{1'b1, 2'd3, 1'b0, 32'h0000_0000, 32'h1234_5678, 2'b11, 32'h0,         4'h0, 32'h0};
    vecs[11] = '{1'b0, 2'd3, 1'b0, 32'h0040_0001, 32'h0,         2'b11, 32'h0,         4'h0, 32'h0};
    vecs[12] = '{1'b1, 2'd2, 1'b0, 32'h0040_0002, 32'hFFFF_FFFF, 2'b10, 32'h0,         4'h0, 32'h0};
    vecs[13] = '{1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0,         2'b00, 32'h8001_BEEF, 4'hF, 32'h0};
    vecs[14] = '{1'b0, 2'd0, 1'b0, 32'h0000_0101, 32'h0,         2'b00, 32'hFFFF_FFBE, 4'h2, 32'h0};
    vecs[15] = '{1'b0, 2'd1, 1'b1, 32'h0000_0100, 32'h0,         2'b00, 32'h0000_BEEF, 4'h3, 32'h0};
    vecs[16] = '{1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'h0,         2'b00, 32'h0,         4'hF, 32'h0};
    vecs[17] = '{1'b0, 2'd0, 1'b0, 32'h003F_FFFF, 32'h0,         2'b00, 32'h0,         4'h8, 32'h0};
    vecs[18] = '{1'b1, 2'd1, 1'b0, 32'h0000_0103, 32'h0000_5555, 2'b01, 32'h0,         4'h0, 32'h0};

    // Reset with a word store to 0 pending: nothing may reach memory.
    clr = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    check("rst_rv", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_str", 32'(mem_str), 32'd0);
    check("rst_sel", 32'(mem_sel), 32'd0);
    check("rst_maddr", 32'(mem_addr), 32'd0);
    check("rst_din", mem_data_in, 32'd0);
    clr = 1'b0; req_valid = 1'b0;
    #1 check("rst_ready_after", 32'(req_ready), 32'd1);

    for (int i = 0; i < 19; i++)
      do_req($sformatf("vec%0d", i), vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr,
             vecs[i].wd, vecs[i].err, vecs[i].rdata, vecs[i].sel, vecs[i].din);

    // clr while the load sits in RD_CAP: the load is dropped silently.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h100;
    #1 check("clr_ld_issue", 32'(mem_ld), 32'd1);
    @(negedge clk);
    req_we = 1'b1; req_wdata = 32'h0; clr = 1'b1;
    #1;
    check("clr_ready", 32'(req_ready), 32'd0);
    check("clr_str", 32'(mem_str), 32'd0);
    check("clr_ld", 32'(mem_ld), 32'd0);
    check("clr_sel", 32'(mem_sel), 32'd0);
    @(negedge clk);
    clr = 1'b0; req_valid = 1'b0;
    check("clr_rv", 32'(resp_valid), 32'd0);
    #1 check("clr_ready_after", 32'(req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("clr_quiet%0d", i), 32'(resp_valid), 32'd0);
    end
    do_req("clr_lw", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 2'b00, 32'h8001_BEEF, 4'hF, 32'h0);

    // Back-to-back SW/SW/LW with req_valid held high.
    pulses = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h200; req_wdata = 32'h1234_5678;
    #1;
    check("b2b_str0", 32'(mem_str), 32'd1);
    check("b2b_maddr0", 32'(mem_addr), 32'h80);
    @(negedge clk);
    pulses += int'(resp_valid);
    check("b2b_rv0", 32'(resp_valid), 32'd1);
    req_addr = 32'h204; req_wdata = 32'hCAFE_F00D;
    #1;
    check("b2b_ready1", 32'(req_ready), 32'd1);
    check("b2b_str1", 32'(mem_str), 32'd1);
    check("b2b_maddr1", 32'(mem_addr), 32'h81);
    @(negedge clk);
    pulses += int'(resp_valid);
    check("b2b_rv1", 32'(resp_valid), 32'd1);
    req_we = 1'b0; req_addr = 32'h200;
    #1 check("b2b_ld", 32'(mem_ld), 32'd1);
    @(negedge clk);
    pulses += int'(resp_valid);
    req_valid = 1'b0;
    check("b2b_cap_rv", 32'(resp_valid), 32'd0);
    @(negedge clk);
    pulses += int'(resp_valid);
    check("b2b_ld_rv", 32'(resp_valid), 32'd1);
    check("b2b_ld_rdata", resp_rdata, 32'h1234_5678);
    repeat (2) begin
      @(negedge clk);
      pulses += int'(resp_valid);
    end
    check("b2b_pulses", 32'(pulses), 32'd3);
    ref_store(2'd2, 32'h200, 32'h1234_5678);
    ref_store(2'd2, 32'h204, 32'hCAFE_F00D);

    // Randomized accesses against the reference model.
    for (int n = 0; n < 150; n++) begin
      logic        we, uns;
      logic [1:0]  sz, e;
      logic [31:0] addr, wd, exp_rd;
      int          r;
      r    = int'($urandom_range(0, 9));
      sz   = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      addr = 32'($urandom_range(0, 4095));
      if (sz != 2'd3 && $urandom_range(0, 3) != 0) addr = addr & ~(32'((1 << sz) - 1));
      if ($urandom_range(0, 9) == 0) addr = addr | (32'd1 << $urandom_range(22, 31));
      we   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      wd   = $urandom;
      e    = m_err(sz, addr);
      exp_rd = (e == 2'b00 && !we) ? m_load(sz, uns, addr) : 32'h0;
      do_req($sformatf("rnd%0d", n), we, sz, uns, addr, wd, e, exp_rd,
             m_sel(sz, addr), m_din(sz, wd));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_ADDR_BITS, default 20, giving the word-address width of the downstream data memory.
REQ-002 The block SHALL have parameter MEM_DATA_BITS, default 32, giving the memory word width; only 32 is supported.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset; the ports are named clk and clr.
REQ-004 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock, all state updates on the rising edge
- clr  in  1  synchronous active-high reset
- req_valid  in  1  access request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 = byte, 01 = half, 10 = word; 11 is reserved
- req_unsigned  in  1  zero-extend loads (LBU/LHU)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  2  00 ok, 01 misaligned, 10 out of range, 11 reserved size
- mem_addr  out  MEM_ADDR_BITS  word address to memory
- mem_data_in  out  32  lane-replicated store data
- mem_sel  out  4  byte enables; sel[0] = bits 7:0 (little-endian)
- mem_str  out  1  memory write strobe
- mem_ld  out  1  memory read strobe
- mem_data_out  in  32  registered, sel-masked memory read data; zeroed by memory when ld = 0

Function
REQ-005 The FSM SHALL have the states IDLE, RD_CAP and RESP, and req_ready SHALL be 1 only in IDLE.
REQ-006 A request is accepted in IDLE when req_valid = 1; the memory outputs SHALL be driven combinationally from the request in that same cycle (cycle 0).
REQ-007 mem_addr SHALL equal req_addr[MEM_ADDR_BITS+1:2].
REQ-008 mem_sel SHALL be set by access size:
- byte: 4'b0001 << addr[1:0]
- half: 4'b0011 << addr[1:0]
- word: 4'b1111
REQ-009 mem_data_in SHALL replicate the store data across lanes:
- byte: {4{wdata[7:0]}}
- half: {2{wdata[15:0]}}
- word: wdata
REQ-010 A store SHALL assert mem_str = 1 and mem_ld = 0 in cycle 0, stay in IDLE, and pulse resp_valid in cycle 1 with resp_err = 00 and resp_rdata = 0.
REQ-011 A load SHALL assert mem_ld = 1 and mem_str = 0 in cycle 0 and then move to RD_CAP.
REQ-012 In RD_CAP (cycle 1) the block SHALL:
- capture mem_data_out, shift the addressed lane to bit 0, and sign- or zero-extend it per req_unsigned into a result register;
- drive mem_ld = 0;
- move to RESP.
REQ-013 In RESP (cycle 2) the block SHALL pulse resp_valid with the result and return to IDLE, so load latency is 2 cycles and load throughput is one per 3 cycles.
REQ-014 The request fields (size, offset, unsigned) SHALL be registered at acceptance, so req_* may change after cycle 0.
REQ-015 A misaligned access SHALL issue no memory strobe and pulse resp_valid in cycle 1 with resp_err = 01; misaligned means half with addr[0] = 1, or word with addr[1:0] != 0.
REQ-016 An out-of-range access SHALL issue no strobe and give resp_err = 10 in cycle 1; out of range means req_addr[31:MEM_ADDR_BITS+2] != 0.
REQ-017 Reserved size 11 SHALL issue no strobe and give resp_err = 11 in cycle 1.
REQ-018 When more than one error applies, resp_err SHALL follow the priority 11 > 10 > 01.
REQ-019 Outside an accepted cycle 0, mem_str, mem_ld and mem_sel SHALL be 0, and mem_addr and mem_data_in SHALL be 0.
REQ-020 resp_valid SHALL be high for exactly one cycle per accepted request.
REQ-021 A new request SHALL be acceptable in the same cycle as a store or error response pulse.

Reset
REQ-022 On clr = 1 at a clock edge, the block SHALL:
- force state to IDLE;
- set resp_valid = 0, resp_rdata = 0, resp_err = 00 and clear the result register;
- drop any in-flight load, with no response ever issued for it.
REQ-023 While clr = 1, req_ready SHALL be 0 and all mem_* outputs SHALL be 0.
REQ-024 A store write already taken by memory at an earlier edge SHALL NOT be undone by clr.

Structure
REQ-025 A shared header mem_defs.vh SHALL hold:
- size codes
- resp_err codes
- FSM state encodings
REQ-026 Lane select and extension SHALL live in one combinational sub-module, mem_load_extract, with inputs (word, offset, size, unsigned) and a 32-bit output.

Verification
REQ-027 SW 0xDEADBEEF at 0x100, then LW 0x100 -> resp_rdata = 0xDEADBEEF two cycles after acceptance; mem_sel = 4'b1111.
REQ-028 SB 0x80 at 0x103, then LB 0x103 -> 0xFFFFFF80, and LBU 0x103 -> 0x00000080; the store drives mem_sel = 4'b1000 and mem_data_in = 0x80808080.
REQ-029 SH 0x8001 at 0x102, then LH -> 0xFFFF8001, and LHU -> 0x00008001; the store drives mem_sel = 4'b1100.
REQ-030 LW 0x101 -> resp_err = 01 in cycle 1, mem_ld never 1; LH 0x00400000 (MEM_ADDR_BITS = 20) -> resp_err = 10.
REQ-031 clr asserted in RD_CAP -> no resp_valid, req_ready = 1 the cycle after clr drops, and the next LW returns correct data.
REQ-032 req_valid held high for back-to-back SW/SW/LW -> stores accepted on consecutive cycles, the load response follows, and resp_valid pulses exactly 3 times.
